// File: rtl/route_chain_emitter.sv
// Route chain emitter: stacks the backward-pass edges of a shortest-path search, then replays
// them start-to-end as an ordered node chain over a valid/ready stream.
module route_chain_emitter #(
    parameter int unsigned NODES     = 65,
    parameter int unsigned EDGES     = 1034,
    parameter int unsigned MAX_LEVEL = 10,
    parameter int unsigned NODE_W    = 7,
    parameter int unsigned EDGE_W    = 11
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              search_start,
    input  logic [NODE_W-1:0] start_point,
    input  logic [NODE_W-1:0] end_point,
    input  logic              edge_valid,
    input  logic [EDGE_W-1:0] edge_idx,
    input  logic [NODES-1:0]  edge_line,
    input  logic              search_done,
    input  logic              search_fail,
    output logic              edge_full,
    output logic              node_valid,
    input  logic              node_ready,
    output logic [NODE_W-1:0] node_id,
    output logic [EDGE_W-1:0] edge_id_out,
    output logic              node_last,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned SP_W  = $clog2(MAX_LEVEL + 1);
    localparam int unsigned CNT_W = $clog2(NODES + 1);

    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_BAD_CHAIN = 2'd2;
    localparam logic [1:0] ERR_NO_PATH   = 2'd3;

    if (EDGES > (2 ** EDGE_W)) begin : g_bad_edge_w
        $error("EDGE_W too narrow for EDGES");
    end

    typedef enum logic [2:0] {StIdle, StCollect, StEmit, StLoad, StDone, StErr} state_e;

    state_e            state_q;
    logic [SP_W-1:0]   sp_q;
    logic [NODE_W-1:0] cur_q;
    logic [NODE_W-1:0] start_q;
    logic [NODE_W-1:0] end_q;
    logic              node_valid_q;
    logic [NODE_W-1:0] node_id_q;
    logic [EDGE_W-1:0] edge_id_q;
    logic              node_last_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [EDGE_W-1:0] stack_idx  [MAX_LEVEL];
    logic [NODES-1:0]  stack_line [MAX_LEVEL];

    logic              sp_full;
    logic              push_en;
    logic [SP_W-1:0]   top_ptr;
    logic [NODES-1:0]  top_line;
    logic [NODES-1:0]  cur_mask;
    logic [NODES-1:0]  other_line;
    logic [CNT_W-1:0]  line_cnt;
    logic [NODE_W-1:0] enc_other;
    logic              enc_found;
    logic              bad_chain;

    assign sp_full = (sp_q == SP_W'(MAX_LEVEL));
    assign push_en = !search_start && (state_q == StCollect) && edge_valid && !search_fail &&
                     !sp_full;

    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_idx[sp_q]  <= edge_idx;
            stack_line[sp_q] <= edge_line;
        end
    end

    assign top_ptr    = sp_q - SP_W'(1);
    assign top_line   = stack_line[top_ptr];
    // An out-of-range cur shifts to an empty mask, which then fails the touch check.
    assign cur_mask   = NODES'(1) << cur_q;
    assign other_line = top_line & ~cur_mask;

    always_comb begin
        line_cnt  = '0;
        enc_other = '0;
        enc_found = 1'b0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (top_line[i]) line_cnt = line_cnt + CNT_W'(1);
            if (other_line[i] && !enc_found) begin
                enc_other = NODE_W'(i);
                enc_found = 1'b1;
            end
        end
    end

    assign bad_chain = (line_cnt != CNT_W'(2)) || ((top_line & cur_mask) == '0) ||
                       ((sp_q == SP_W'(1)) && (enc_other != end_q));

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q      <= StIdle;
            sp_q         <= '0;
            cur_q        <= '0;
            start_q      <= '0;
            end_q        <= '0;
            node_valid_q <= 1'b0;
            node_id_q    <= '0;
            edge_id_q    <= '0;
            node_last_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else if (search_start) begin
            state_q      <= StCollect;
            sp_q         <= '0;
            start_q      <= start_point;
            end_q        <= end_point;
            node_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            case (state_q)
                StCollect: begin
                    if (search_fail) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_NO_PATH;
                    end else if (edge_valid && sp_full) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_OVERFLOW;
                    end else begin
                        if (edge_valid) sp_q <= sp_q + SP_W'(1);
                        // Emptiness is judged after the same-cycle push.
                        if (search_done) begin
                            if (!edge_valid && (sp_q == '0) && (start_q != end_q)) begin
                                state_q    <= StErr;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_BAD_CHAIN;
                            end else begin
                                node_id_q    <= start_q;
                                edge_id_q    <= '0;
                                node_last_q  <= !edge_valid && (sp_q == '0);
                                node_valid_q <= 1'b1;
                                state_q      <= StEmit;
                            end
                        end
                    end
                end
                StEmit: begin
                    if (node_ready) begin
                        cur_q        <= node_id_q;
                        node_valid_q <= 1'b0;
                        state_q      <= node_last_q ? StDone : StLoad;
                    end
                end
                StLoad: begin
                    if (bad_chain) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BAD_CHAIN;
                    end else begin
                        node_id_q    <= enc_other;
                        edge_id_q    <= stack_idx[top_ptr];
                        node_last_q  <= (sp_q == SP_W'(1));
                        sp_q         <= top_ptr;
                        node_valid_q <= 1'b1;
                        state_q      <= StEmit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign edge_full   = sp_full;
    assign node_valid  = node_valid_q;
    assign node_id     = node_id_q;
    assign edge_id_out = edge_id_q;
    assign node_last   = node_last_q;
    assign busy        = (state_q == StCollect) || (state_q == StEmit) || (state_q == StLoad);
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_route_chain_emitter.sv
// Directed bench for route_chain_emitter: chain ordering, timing, backpressure and error paths.
module tb_route_chain_emitter;

    localparam int unsigned NODES  = 65;
    localparam int unsigned NODE_W = 7;
    localparam int unsigned EDGE_W = 11;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b0;
    logic              search_start = 1'b0;
    logic [NODE_W-1:0] start_point = '0;
    logic [NODE_W-1:0] end_point = '0;
    logic              edge_valid = 1'b0;
    logic [EDGE_W-1:0] edge_idx = '0;
    logic [NODES-1:0]  edge_line = '0;
    logic              search_done = 1'b0;
    logic              search_fail = 1'b0;
    logic              edge_full;
    logic              node_valid;
    logic              node_ready = 1'b0;
    logic [NODE_W-1:0] node_id;
    logic [EDGE_W-1:0] edge_id_out;
    logic              node_last;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    route_chain_emitter dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .search_start(search_start),
        .start_point (start_point),
        .end_point   (end_point),
        .edge_valid  (edge_valid),
        .edge_idx    (edge_idx),
        .edge_line   (edge_line),
        .search_done (search_done),
        .search_fail (search_fail),
        .edge_full   (edge_full),
        .node_valid  (node_valid),
        .node_ready  (node_ready),
        .node_id     (node_id),
        .edge_id_out (edge_id_out),
        .node_last   (node_last),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    function automatic logic [NODES-1:0] pair(input int a, input int b);
        logic [NODES-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        return m;
    endfunction

    // {node_valid, node_id, edge_id_out, node_last}
    function automatic logic [19:0] obs();
        return {node_valid, node_id, edge_id_out, node_last};
    endfunction

    function automatic logic [19:0] nd(input int v, input int id, input int e, input int l);
        return {1'(v), NODE_W'(id), EDGE_W'(e), 1'(l)};
    endfunction

    // {busy, err, err_code, edge_full}
    function automatic logic [4:0] sts();
        return {busy, err, err_code, edge_full};
    endfunction

    function automatic logic [4:0] st(input int b, input int e, input int c, input int f);
        return {1'(b), 1'(e), 2'(c), 1'(f)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_search(input int s, input int e);
        search_start = 1'b1;
        start_point  = NODE_W'(s);
        end_point    = NODE_W'(e);
        tick();
        search_start = 1'b0;
    endtask

    task automatic push(input int idx, input logic [NODES-1:0] line);
        edge_valid = 1'b1;
        edge_idx   = EDGE_W'(idx);
        edge_line  = line;
        tick();
        edge_valid = 1'b0;
    endtask

    task automatic done();
        search_done = 1'b1;
        tick();
        search_done = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (obs() !== nd(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_node: got %h want %h", obs(), nd(0, 0, 0, 0));
        end
        vectors++;
        if (sts() !== st(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_status: got %h want %h", sts(), st(0, 0, 0, 0));
        end
        RST_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_search(3, 7);
        vectors++;
        if (sts() !== st(1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL basic_collect: got %h want %h", sts(), st(1, 0, 0, 0));
        end
        push(100, pair(7, 5));
        push(42, pair(5, 3));
        node_ready = 1'b1;
        done();
        vectors++;
        if (obs() !== nd(1, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL basic_n0: got %h want %h", obs(), nd(1, 3, 0, 0));
        end
        tick();
        vectors++;
        if (node_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gap: got %b want 0", node_valid);
        end
        tick();
        vectors++;
        if (obs() !== nd(1, 5, 42, 0)) begin
            miscompares++;
            $display("FAIL basic_n1: got %h want %h", obs(), nd(1, 5, 42, 0));
        end
        tick();
        tick();
        vectors++;
        if (obs() !== nd(1, 7, 100, 1)) begin
            miscompares++;
            $display("FAIL basic_n2: got %h want %h", obs(), nd(1, 7, 100, 1));
        end
        tick();
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 0, 0, 0)}) begin
            miscompares++;
            $display("FAIL basic_done: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 0, 0, 0)});
        end
        node_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        start_search(3, 7);
        push(100, pair(7, 5));
        push(42, pair(5, 3));
        node_ready = 1'b1;
        done();
        tick();
        tick();
        node_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== nd(1, 5, 42, 0)) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got %h want %h", i, obs(), nd(1, 5, 42, 0));
            end
        end
        node_ready = 1'b1;
        tick();
        vectors++;
        if (node_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_gap: got %b want 0", node_valid);
        end
        tick();
        vectors++;
        if (obs() !== nd(1, 7, 100, 1)) begin
            miscompares++;
            $display("FAIL bp_n2: got %h want %h", obs(), nd(1, 7, 100, 1));
        end
        node_ready = 1'b0;
    endtask

    task automatic test_overflow();
        start_search(1, 2);
        for (int i = 0; i < 10; i++) begin
            push(i + 1, pair(1, 2));
            vectors++;
            if (edge_full !== (i == 9)) begin
                miscompares++;
                $display("FAIL ovf_full%0d: got %b want %b", i, edge_full, (i == 9));
            end
        end
        push(11, pair(1, 2));
        vectors++;
        if (sts() !== st(0, 1, 1, 1)) begin
            miscompares++;
            $display("FAIL ovf_err: got %h want %h", sts(), st(0, 1, 1, 1));
        end
        node_ready = 1'b1;
        done();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({node_valid, err_code} !== 3'b001) begin
                miscompares++;
                $display("FAIL ovf_quiet%0d: got %b want 001", i, {node_valid, err_code});
            end
            tick();
        end
        node_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        start_search(3, 7);
        push(100, pair(7, 5));
        edge_valid  = 1'b1;
        edge_idx    = EDGE_W'(42);
        edge_line   = pair(5, 3);
        search_done = 1'b1;
        tick();
        edge_valid  = 1'b0;
        search_done = 1'b0;
        vectors++;
        if (obs() !== nd(1, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL same_n0: got %h want %h", obs(), nd(1, 3, 0, 0));
        end
        node_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (obs() !== nd(1, 5, 42, 0)) begin
            miscompares++;
            $display("FAIL same_n1: got %h want %h", obs(), nd(1, 5, 42, 0));
        end
        tick();
        tick();
        vectors++;
        if (obs() !== nd(1, 7, 100, 1)) begin
            miscompares++;
            $display("FAIL same_n2: got %h want %h", obs(), nd(1, 7, 100, 1));
        end
        tick();
        node_ready = 1'b0;
    endtask

    task automatic test_bad_chain();
        logic [NODES-1:0] three;
        three    = pair(3, 5);
        three[9] = 1'b1;
        node_ready = 1'b1;
        start_search(3, 7);
        push(100, pair(7, 5));
        push(42, three);
        done();
        vectors++;
        if (obs() !== nd(1, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL bad3_n0: got %h want %h", obs(), nd(1, 3, 0, 0));
        end
        tick();
        tick();
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 1, 2, 0)}) begin
            miscompares++;
            $display("FAIL bad3_err: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 1, 2, 0)});
        end
        start_search(3, 7);
        push(42, pair(5, 3));
        done();
        vectors++;
        if (obs() !== nd(1, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL badend_n0: got %h want %h", obs(), nd(1, 3, 0, 0));
        end
        tick();
        tick();
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 1, 2, 0)}) begin
            miscompares++;
            $display("FAIL badend_err: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 1, 2, 0)});
        end
        start_search(3, 7);
        done();
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 1, 2, 0)}) begin
            miscompares++;
            $display("FAIL empty_err: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 1, 2, 0)});
        end
        node_ready = 1'b0;
    endtask

    task automatic test_trivial();
        node_ready = 1'b1;
        start_search(9, 9);
        done();
        vectors++;
        if (obs() !== nd(1, 9, 0, 1)) begin
            miscompares++;
            $display("FAIL triv_n0: got %h want %h", obs(), nd(1, 9, 0, 1));
        end
        tick();
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 0, 0, 0)}) begin
            miscompares++;
            $display("FAIL triv_done: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 0, 0, 0)});
        end
        node_ready = 1'b0;
    endtask

    task automatic test_no_path();
        node_ready = 1'b1;
        start_search(1, 2);
        for (int i = 0; i < 4; i++) push(i + 20, pair(1, 2));
        search_fail = 1'b1;
        tick();
        search_fail = 1'b0;
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 1, 3, 0)}) begin
            miscompares++;
            $display("FAIL nopath_err: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 1, 3, 0)});
        end
        done();
        vectors++;
        if ({node_valid, err_code} !== 3'b011) begin
            miscompares++;
            $display("FAIL nopath_quiet: got %b want 011", {node_valid, err_code});
        end
        start_search(1, 2);
        push(30, pair(1, 2));
        search_fail = 1'b1;
        search_done = 1'b1;
        tick();
        search_fail = 1'b0;
        search_done = 1'b0;
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(0, 1, 3, 0)}) begin
            miscompares++;
            $display("FAIL faildone_err: got %h want %h", {node_valid, sts()}, {1'b0, st(0, 1, 3, 0)});
        end
        tick();
        vectors++;
        if (node_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL faildone_quiet: got %b want 0", node_valid);
        end
        node_ready = 1'b0;
    endtask

    task automatic test_restart();
        start_search(3, 7);
        vectors++;
        if (sts() !== st(1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL rst_errclr: got %h want %h", sts(), st(1, 0, 0, 0));
        end
        push(100, pair(7, 5));
        push(42, pair(5, 3));
        node_ready = 1'b0;
        done();
        tick();
        vectors++;
        if (obs() !== nd(1, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL rst_stall: got %h want %h", obs(), nd(1, 3, 0, 0));
        end
        start_search(2, 4);
        vectors++;
        if ({node_valid, sts()} !== {1'b0, st(1, 0, 0, 0)}) begin
            miscompares++;
            $display("FAIL rst_drop: got %h want %h", {node_valid, sts()}, {1'b0, st(1, 0, 0, 0)});
        end
        push(11, pair(6, 4));
        push(12, pair(2, 6));
        node_ready = 1'b1;
        done();
        vectors++;
        if (obs() !== nd(1, 2, 0, 0)) begin
            miscompares++;
            $display("FAIL rst_n0: got %h want %h", obs(), nd(1, 2, 0, 0));
        end
        tick();
        tick();
        vectors++;
        if (obs() !== nd(1, 6, 12, 0)) begin
            miscompares++;
            $display("FAIL rst_n1: got %h want %h", obs(), nd(1, 6, 12, 0));
        end
        tick();
        tick();
        vectors++;
        if (obs() !== nd(1, 4, 11, 1)) begin
            miscompares++;
            $display("FAIL rst_n2: got %h want %h", obs(), nd(1, 4, 11, 1));
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_done: got %b want 0", busy);
        end
        node_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_same_cycle();
        test_bad_chain();
        test_trivial();
        test_no_path();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
